// File: rtl/word_memory_arbiter_pkg.sv
// rtl/word_memory_arbiter_pkg.sv - shared state encoding, width defaults and index helper
package word_memory_arbiter_pkg;

    localparam int ADDR_BITS_DEFAULT = 10;
    localparam int DATA_BITS_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Never narrower than one bit, so a two-core build still has an index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/word_memory_arbiter_if.sv
// rtl/word_memory_arbiter_if.sv - per-core request/acknowledge bus between core array and arbiter
interface word_memory_arbiter_if
    import word_memory_arbiter_pkg::*;
#(
    parameter int NumCores = 4,
    parameter int AddrBits = ADDR_BITS_DEFAULT,
    parameter int DataBits = DATA_BITS_DEFAULT
);
    logic [NumCores-1:0]          Req;
    logic [NumCores-1:0]          WriteEnable;
    logic [NumCores-1:0]          Lock;
    logic [NumCores*AddrBits-1:0] Addr;
    logic [NumCores*DataBits-1:0] InputData;
    logic [NumCores-1:0]          Ack;
    logic [DataBits-1:0]          OutputData;

    modport master (
        output Req, WriteEnable, Lock, Addr, InputData,
        input  Ack, OutputData
    );

    modport slave (
        input  Req, WriteEnable, Lock, Addr, InputData,
        output Ack, OutputData
    );
endinterface

// File: rtl/word_memory_arbiter_rr_priority_select.sv
// rtl/word_memory_arbiter_rr_priority_select.sv - combinational round-robin pick from a pointer
module rr_priority_select
    import word_memory_arbiter_pkg::*;
#(
    parameter  int NumCores = 4,
    localparam int IdxBits  = clog2(NumCores)
) (
    input  logic [NumCores-1:0] eligible,
    input  logic [IdxBits-1:0]  pointer,
    output logic                valid,
    output logic [IdxBits-1:0]  winner
);
    always_comb begin
        int idx;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // Walk farthest offset first so the core nearest the pointer is written last and wins.
        for (int k = NumCores - 1; k >= 0; k--) begin
            idx = (int'(pointer) + k) % NumCores;
            if (eligible[idx]) begin
                valid  = 1'b1;
                winner = IdxBits'(idx);
            end
        end
    end
endmodule

// File: rtl/word_memory_arbiter.sv
// rtl/word_memory_arbiter.sv - round-robin arbiter with lock for a shared single-port word memory
module word_memory_arbiter
    import word_memory_arbiter_pkg::*;
#(
    parameter int NumCores    = 4,
    parameter int AddrBits    = ADDR_BITS_DEFAULT,
    parameter int DataBits    = DATA_BITS_DEFAULT,
    parameter int LockTimeout = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    word_memory_arbiter_if.slave core_bus,
    output logic                 MemChipEnable,
    output logic                 MemWriteEnable,
    output logic [AddrBits-1:0]  MemAddr,
    output logic [DataBits-1:0]  MemInputData,
    input  logic [DataBits-1:0]  MemOutputData
);
    localparam int IdxBits  = clog2(NumCores);
    localparam int TmoBits  = clog2(LockTimeout + 1);
    localparam int LastCore = NumCores - 1;

    state_e              state_q, state_d;
    logic [NumCores-1:0] ack_q, ack_d;
    logic [DataBits-1:0] out_q, out_d;
    logic [IdxBits-1:0]  grant_q, grant_d;
    logic [AddrBits-1:0] addr_q, addr_d;
    logic [DataBits-1:0] wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                lock_cap_q, lock_cap_d;
    logic [IdxBits-1:0]  ptr_q, ptr_d;
    logic                lock_held_q, lock_held_d;
    logic [IdxBits-1:0]  owner_q, owner_d;
    logic [TmoBits-1:0]  tmo_q, tmo_d;

    logic [NumCores-1:0] eligible;
    logic                win_valid;
    logic [IdxBits-1:0]  win_idx;

    function automatic logic [IdxBits-1:0] next_idx(input logic [IdxBits-1:0] i);
        return (int'(i) == LastCore) ? '0 : i + 1'b1;
    endfunction

    // The just-acknowledged core may still show Req while it drops it.
    always_comb begin
        eligible = core_bus.Req & ~ack_q;
        if (lock_held_q) eligible = eligible & (NumCores'(1) << owner_q);
    end

    rr_priority_select #(.NumCores(NumCores)) u_select (
        .eligible (eligible),
        .pointer  (ptr_q),
        .valid    (win_valid),
        .winner   (win_idx)
    );

    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        out_d       = out_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        lock_cap_d  = lock_cap_q;
        ptr_d       = ptr_q;
        lock_held_d = lock_held_q;
        owner_d     = owner_q;
        tmo_d       = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d    = ST_ACCESS;
                    grant_d    = win_idx;
                    addr_d     = core_bus.Addr[win_idx*AddrBits +: AddrBits];
                    wdata_d    = core_bus.InputData[win_idx*DataBits +: DataBits];
                    we_d       = core_bus.WriteEnable[win_idx];
                    lock_cap_d = core_bus.Lock[win_idx];
                    if (lock_held_q) tmo_d = '0;
                end else if (lock_held_q) begin
                    // Owner is not asking this cycle; an abandoned lock must not starve others.
                    if (tmo_q == TmoBits'(LockTimeout - 1)) begin
                        lock_held_d = 1'b0;
                        tmo_d       = '0;
                        ptr_d       = next_idx(owner_q);
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                state_d        = ST_IDLE;
                ack_d[grant_q] = 1'b1;
                if (!we_q) out_d = MemOutputData;
                if (lock_cap_q) begin
                    lock_held_d = 1'b1;
                    owner_d     = grant_q;
                    tmo_d       = '0;
                end else begin
                    lock_held_d = 1'b0;
                    ptr_d       = next_idx(grant_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ack_q       <= '0;
            out_q       <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            lock_cap_q  <= 1'b0;
            ptr_q       <= '0;
            lock_held_q <= 1'b0;
            owner_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            out_q       <= out_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            lock_cap_q  <= lock_cap_d;
            ptr_q       <= ptr_d;
            lock_held_q <= lock_held_d;
            owner_q     <= owner_d;
            tmo_q       <= tmo_d;
        end
    end

    // rst_n gating kills a write already in flight when reset lands mid-access.
    always_comb begin
        MemChipEnable  = 1'b0;
        MemWriteEnable = 1'b0;
        MemAddr        = '0;
        MemInputData   = '0;
        if (state_q == ST_ACCESS) begin
            MemChipEnable  = rst_n;
            MemWriteEnable = rst_n & we_q;
            MemAddr        = addr_q;
            MemInputData   = wdata_q;
        end
    end

    assign core_bus.Ack        = ack_q;
    assign core_bus.OutputData = out_q;

endmodule

// File: doc/word_memory_arbiter.md
# word_memory_arbiter

Round-robin arbiter that shares one 1024 x 8 word memory between up to NumCores PLC cores. Each core issues single-word read or write requests; the arbiter serialises them onto the memory's write-enable, chip-enable, address and data ports, returns read data and a one-cycle acknowledge, and supports a lock so a core can perform atomic read-modify-write sequences. It sits between the core array and the word memory instance.

## Interface
Parameters:
- NumCores, 4: number of requesting cores (2..8)
- AddrBits, 10: memory address width
- DataBits, 8: memory data width
- LockTimeout, 16: idle cycles after which an unused lock is released

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- Req  in  NumCores  per-core request, held high until its Ack
- WriteEnable  in  NumCores  per-core: 1 = write, 0 = read
- Lock  in  NumCores  per-core: keep ownership after this access
- Addr  in  NumCores*AddrBits  per-core address, core i at [i*AddrBits +: AddrBits]
- InputData  in  NumCores*DataBits  per-core write data, same packing
- Ack  out  NumCores  one-hot, one-cycle completion pulse
- OutputData  out  DataBits  registered read data, valid in Ack cycle
- MemChipEnable  out  1  to memory chip_enable
- MemWriteEnable  out  1  to memory WriteEnable
- MemAddr  out  AddrBits  to memory Addr
- MemInputData  out  DataBits  to memory InputData
- MemOutputData  in  DataBits  from memory OutputData; combinational read, high-Z when chip-enable is low

## Operation
- States: IDLE, ACCESS.
- IDLE: the eligible request set is Req masked by the current Ack, since the acknowledged core is still dropping Req.
  - Lock owned: only the owner is eligible.
  - Otherwise: search from the pointer upward, wrapping; the first eligible core wins.
  - On a win: register grant index, Addr, InputData, WriteEnable and Lock of the winner, then go to ACCESS.
- ACCESS:
  - Drive MemChipEnable=1, MemWriteEnable=captured WE, MemAddr and MemInputData from the capture registers.
  - At the closing edge:
    - OutputData <= MemOutputData on a read; unchanged on a write.
    - Ack[grant] <= 1.
    - State returns to IDLE.
- Pointer and lock update at the end of ACCESS:
  - Captured Lock=1: lock owner = grant; pointer unchanged.
  - Captured Lock=0: lock released; pointer = grant+1 mod NumCores.
- Lock timeout: the counter resets on every owner grant and increments each cycle the owner has no Req. At LockTimeout the lock is released and pointer = owner+1.
- Memory ports are 0 / don't-care outside ACCESS. MemChipEnable is low in IDLE, so MemOutputData is never sampled while high-Z.
- Memory writes only ever happen in ACCESS with MemWriteEnable=1.

## Timing
- Reset values (rst_n low at an edge):
  - state IDLE, Ack=0, OutputData=0, pointer=0, lock free, timeout counter 0.
  - All Mem* outputs 0. MemChipEnable and MemWriteEnable are also gated combinationally by rst_n.
- Latency: Req sampled high at edge k gives ACCESS in cycle k+1 and Ack high in cycle k+2, with OutputData valid in that cycle.
- Throughput: one access per 2 cycles.
- A core re-asserting Req in the cycle after its Ack is eligible in that cycle's IDLE.
- Simultaneous requests: round-robin order starting at the pointer.
- Request changes while waiting: Addr/InputData/WriteEnable changes after capture are ignored. A Req dropped before grant is simply not served.
- Reset asserted during ACCESS: the memory write is suppressed by gating and no Ack is issued.
- Lock owner also requesting at the timeout edge: the grant takes priority and the counter resets.

## Structure
- Shared package: state encoding (IDLE/ACCESS), AddrBits/DataBits defaults matching the word memory, and an index-width function clog2(NumCores).
- One sub-module, rr_priority_select: combinational round-robin pick from an eligible vector and a pointer, returning a valid flag and the winner index.
- Pointer, lock and timeout logic stay in the top module.

## Test plan
- Single write then read:
  - Core 0 writes 0xA5 to address 0x123. Ack[0] arrives 2 cycles after Req.
  - Core 0 then reads 0x123: OutputData=0xA5 in the Ack cycle.
- Contention: all 4 cores request reads at once with pointer=0. Acks arrive in order 0,1,2,3, spaced 2 cycles apart; final pointer=0.
- Fairness: core 1 re-requests immediately after each Ack while core 2 holds Req. Grants alternate 1,2,1,2.
- Locked read-modify-write:
  - Core 2 reads 0x010 (value 0x07) with Lock=1 while cores 0 and 3 request.
  - Core 2 then writes 0x08 with Lock=0 before any other grant.
  - Next grant goes to core 3, then core 0.
- Lock timeout: core 1 reads with Lock=1 and then idles while core 0 requests. Core 0 is granted only after 16 idle cycles; pointer=2 afterwards.
- Reset mid-access: rst_n pulled low during a write ACCESS to 0x3FF. Memory 0x3FF stays unchanged, Ack stays 0, and all outputs hold their reset values.
